alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Alarm sequencer for the digital watch.
- Compares the running time digits (hh_t..mm_u) against the alarm digits (ah_t..am_u) from watch_fsm and, on a new match, drives a pulsed buzzer.
- Handles snooze with a limited snooze count, ring timeout, and stop/disarm.
- Sits beside watch_fsm, consumes its state_out and the 1 Hz sec_tick, and drives the buzzer pin and status LEDs.

Parameters:
RING_SECS, 60, sec_ticks a ring burst lasts before auto-timeout (>=2)
SNOOZE_SECS, 300, sec_ticks spent in snooze before re-ringing (>=2)
MAX_SNOOZE, 3, maximum snoozes per alarm event (1..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sec_tick  in  1  one-clk-wide 1 Hz enable
alarm_en  in  1  level; 1 = alarm armed by user
snooze_btn  in  1  one-clk pulse
stop_btn  in  1  one-clk pulse
state_out  in  2  watch_fsm mode (00 NORMAL, 01 SET_TIME, 10 SET_ALARM, 11 STOP_WATCH)
hh_t, hh_u, mm_t, mm_u  in  4 each  current time BCD digits
ah_t, ah_u, am_t, am_u  in  4 each  alarm BCD digits
buzzer  out  1  buzzer drive
ringing  out  1  1 while in RINGING
snoozing  out  1  1 while in SNOOZE
snooze_cnt  out  2  snoozes used in the current event
missed  out  1  sticky: a ring burst timed out unanswered
alarm_state  out  2  00 DISARMED, 01 ARMED, 10 RINGING, 11 SNOOZE

Behaviour:
- Reset (rst=0, async) values:
  - state DISARMED
  - tick counter 0
  - snooze_cnt 0
  - missed 0
  - buzzer 0
  - phase 0
  - match_d 1 (prevents a ring right after reset when time==alarm==00:00)
- Match logic:
  - match = all four time digits equal the alarm digits.
  - match_d registers match every clk.
  - fire = match & ~match_d & ~inhibit, where inhibit = (state_out==01 | state_out==10).
  - A fire that is inhibited is lost; it is not deferred.
  - Arming while match is already 1 does not ring.
- Tick counter: width ceil(log2(max(RING_SECS,SNOOZE_SECS))). Cleared on every state entry. Increments only on sec_tick in RINGING/SNOOZE.
- Transition priority each clk: alarm_en=0 > stop_btn > snooze_btn > timeout > fire.
- DISARMED:
  - alarm_en=1 -> ARMED next clk.
  - Buttons are ignored here except stop_btn, which clears missed.
- ARMED:
  - alarm_en=0 -> DISARMED.
  - stop_btn clears missed.
  - fire -> RINGING, snooze_cnt<=0.
- RINGING:
  - alarm_en=0 -> DISARMED; snooze_cnt<=0, missed<=0.
  - stop_btn -> ARMED; snooze_cnt<=0, missed<=0.
  - snooze_btn with snooze_cnt<MAX_SNOOZE -> SNOOZE; snooze_cnt+1.
  - snooze_btn with snooze_cnt==MAX_SNOOZE is ignored (stays RINGING, counter unaffected).
  - sec_tick with counter==RING_SECS-1 -> ARMED; missed<=1, snooze_cnt<=0. The burst therefore lasts exactly RING_SECS ticks.
- SNOOZE:
  - alarm_en=0 and stop_btn behave as in RINGING.
  - snooze_btn is ignored.
  - sec_tick with counter==SNOOZE_SECS-1 -> RINGING.
- Buzzer:
  - phase is set to 1 on every RINGING entry and toggles on each sec_tick while RINGING.
  - buzzer = (state==RINGING) & phase, registered, giving a 1 s on / 1 s off pattern.
  - buzzer is 0 in all other states.
- Outputs are registered and valid 1 clk after the causing edge.
- ringing, snoozing and alarm_state decode the state register directly.
- A fire while already RINGING/SNOOZE is ignored.
- Time keeps advancing during STOP_WATCH; alarms fire there normally.
- Async reset mid-ring drops buzzer immediately.

Test Plan:
- Reset with time=alarm=00:00, alarm_en=1, 5 ticks -> alarm_state=01, buzzer never 1, ringing=0.
- RING_SECS=4: alarm 06:45, time steps 06:44->06:45, state_out=00 -> ringing=1 next clk; buzzer 1,0,1,0 across ticks; after 4 ticks alarm_state=01, missed=1.
- SNOOZE_SECS=6, MAX_SNOOZE=3: ring, then snooze_btn -> snoozing=1, snooze_cnt=1; 6 ticks -> ringing=1. Repeat to snooze_cnt=3; a 4th snooze_btn keeps ringing=1 and snooze_cnt=3.
- Ringing with snooze_btn and stop_btn in the same clk -> alarm_state=01, snooze_cnt=0, buzzer=0.
- state_out=01 while time steps onto 06:45 -> no ring. Return to 00 still at 06:45 -> no ring (no new rise).
- Ringing, then alarm_en dropped -> alarm_state=00 next clk. Separately, rst pulsed low mid-snooze -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the watch core/buttons and the alarm sequencer.
// master drives time, alarm digits and buttons; slave is the alarm_ctrl side.
interface alarm_ctrl_if;
  logic       sec_tick;
  logic       alarm_en;
  logic       snooze_btn;
  logic       stop_btn;
  logic [1:0] state_out;
  logic [3:0] hh_t;
  logic [3:0] hh_u;
  logic [3:0] mm_t;
  logic [3:0] mm_u;
  logic [3:0] ah_t;
  logic [3:0] ah_u;
  logic [3:0] am_t;
  logic [3:0] am_u;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;
  logic       missed;
  logic [1:0] alarm_state;

  modport master (
    output sec_tick, alarm_en, snooze_btn, stop_btn, state_out,
    output hh_t, hh_u, mm_t, mm_u, ah_t, ah_u, am_t, am_u,
    input  buzzer, ringing, snoozing, snooze_cnt, missed, alarm_state
  );

  modport slave (
    input  sec_tick, alarm_en, snooze_btn, stop_btn, state_out,
    input  hh_t, hh_u, mm_t, mm_u, ah_t, ah_u, am_t, am_u,
    output buzzer, ringing, snoozing, snooze_cnt, missed, alarm_state
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: rings the buzzer on a new time==alarm match, with snooze,
// ring timeout (sticky missed flag) and stop/disarm handling.
module alarm_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic         clk,
  input  logic         rst,
  alarm_ctrl_if.slave  bus
);

  localparam int unsigned MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CNT_W    = (MAX_SECS > 2) ? $clog2(MAX_SECS) : 1;

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
  localparam logic [1:0]       SNOOZE_MAX  = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_RINGING  = 2'b10,
    ST_SNOOZE   = 2'b11
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_snooze_cnt;
  logic             r_missed;
  logic             r_phase;
  logic             r_match_d;
  logic             r_buzzer;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_snooze_cnt_nxt;
  logic             w_missed_nxt;
  logic             w_phase_nxt;
  logic             w_buzzer_nxt;
  logic             w_match;
  logic             w_inhibit;
  logic             w_fire;
  logic             w_active;

  // Only a rising match outside the set modes starts a ring; inhibited rises are lost.
  assign w_match   = (bus.hh_t == bus.ah_t) & (bus.hh_u == bus.ah_u) &
                     (bus.mm_t == bus.am_t) & (bus.mm_u == bus.am_u);
  assign w_inhibit = (bus.state_out == 2'b01) | (bus.state_out == 2'b10);
  assign w_fire    = w_match & ~r_match_d & ~w_inhibit;
  assign w_active  = (r_state == ST_RINGING) | (r_state == ST_SNOOZE);

  // Next-state, counters and buzzer phase.
  always_comb begin
    w_state_nxt      = r_state;
    w_snooze_cnt_nxt = r_snooze_cnt;
    w_missed_nxt     = r_missed;
    w_cnt_nxt        = r_cnt;
    w_phase_nxt      = r_phase;
    w_buzzer_nxt     = 1'b0;

    unique case (r_state)
      ST_DISARMED: begin
        if (bus.stop_btn) w_missed_nxt = 1'b0;
        if (bus.alarm_en) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!bus.alarm_en) begin
          w_state_nxt = ST_DISARMED;
        end else begin
          if (bus.stop_btn) w_missed_nxt = 1'b0;
          if (w_fire) begin
            w_state_nxt      = ST_RINGING;
            w_snooze_cnt_nxt = 2'd0;
          end
        end
      end
      ST_RINGING: begin
        if (!bus.alarm_en) begin
          w_state_nxt      = ST_DISARMED;
          w_snooze_cnt_nxt = 2'd0;
          w_missed_nxt     = 1'b0;
        end else if (bus.stop_btn) begin
          w_state_nxt      = ST_ARMED;
          w_snooze_cnt_nxt = 2'd0;
          w_missed_nxt     = 1'b0;
        end else if (bus.snooze_btn && (r_snooze_cnt < SNOOZE_MAX)) begin
          w_state_nxt      = ST_SNOOZE;
          w_snooze_cnt_nxt = r_snooze_cnt + 2'd1;
        end else if (bus.sec_tick && (r_cnt == RING_LAST)) begin
          w_state_nxt      = ST_ARMED;
          w_snooze_cnt_nxt = 2'd0;
          w_missed_nxt     = 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (!bus.alarm_en) begin
          w_state_nxt      = ST_DISARMED;
          w_snooze_cnt_nxt = 2'd0;
          w_missed_nxt     = 1'b0;
        end else if (bus.stop_btn) begin
          w_state_nxt      = ST_ARMED;
          w_snooze_cnt_nxt = 2'd0;
          w_missed_nxt     = 1'b0;
        end else if (bus.sec_tick && (r_cnt == SNOOZE_LAST)) begin
          w_state_nxt = ST_RINGING;
        end
      end
      default: w_state_nxt = ST_DISARMED;
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
      if (w_state_nxt == ST_RINGING) w_phase_nxt = 1'b1;
    end else if (bus.sec_tick && w_active) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (r_state == ST_RINGING) w_phase_nxt = ~r_phase;
    end

    w_buzzer_nxt = (w_state_nxt == ST_RINGING) & w_phase_nxt;
  end

  // match_d resets high so time==alarm at power-up is not a new match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_DISARMED;
      r_cnt        <= '0;
      r_snooze_cnt <= 2'd0;
      r_missed     <= 1'b0;
      r_phase      <= 1'b0;
      r_match_d    <= 1'b1;
      r_buzzer     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_snooze_cnt <= w_snooze_cnt_nxt;
      r_missed     <= w_missed_nxt;
      r_phase      <= w_phase_nxt;
      r_match_d    <= w_match;
      r_buzzer     <= w_buzzer_nxt;
    end
  end

  assign bus.buzzer      = r_buzzer;
  assign bus.ringing     = (r_state == ST_RINGING);
  assign bus.snoozing    = (r_state == ST_SNOOZE);
  assign bus.snooze_cnt  = r_snooze_cnt;
  assign bus.missed      = r_missed;
  assign bus.alarm_state = r_state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: directed scenarios then random stimulus,
// each cycle's expected outputs come from a seconds-based behavioural model.
module tb_alarm_ctrl;

  localparam int RING   = 4;
  localparam int SNOOZE = 6;
  localparam int MAXSN  = 3;

  typedef struct packed {
    logic [1:0] st;
    logic       ring;
    logic       snz;
    logic       buz;
    logic       missed;
    logic [1:0] sn;
  } exp_t;

  logic clk;
  logic rst;
  alarm_ctrl_if u_if ();

  alarm_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNOOZE), .MAX_SNOOZE(MAXSN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t q_exp[$];

  // drive-side state
  bit          d_rst;
  bit          d_en;
  logic [1:0]  d_so;
  logic [15:0] d_tm;
  logic [15:0] d_al;

  // model: mode 0 off, 1 armed, 2 ringing, 3 snoozing; secs = whole seconds in current mode
  int m_mode, m_secs, m_sn;
  bit m_missed, m_prev_match;

  function automatic int mins_of(input logic [15:0] t);
    return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic void model_step(input bit tick, input bit snz, input bit stop);
    bit match, fire;
    int nm;
    if (!d_rst) begin
      m_mode = 0; m_secs = 0; m_sn = 0; m_missed = 0; m_prev_match = 1;
      return;
    end
    match = (mins_of(d_tm) == mins_of(d_al));
    fire  = match && !m_prev_match && !(d_so == 2'd1 || d_so == 2'd2);
    m_prev_match = match;
    nm = m_mode;
    if (m_mode == 0) begin
      if (stop) m_missed = 0;
      if (d_en) nm = 1;
    end else if (m_mode == 1) begin
      if (!d_en) nm = 0;
      else begin
        if (stop) m_missed = 0;
        if (fire) begin nm = 2; m_sn = 0; end
      end
    end else begin
      if (!d_en) begin nm = 0; m_sn = 0; m_missed = 0; end
      else if (stop) begin nm = 1; m_sn = 0; m_missed = 0; end
      else if (m_mode == 2 && snz && m_sn < MAXSN) begin nm = 3; m_sn++; end
      else if (tick && m_secs + 1 == ((m_mode == 2) ? RING : SNOOZE)) begin
        if (m_mode == 2) begin nm = 1; m_missed = 1; m_sn = 0; end
        else nm = 2;
      end else if (tick) m_secs++;
    end
    if (nm != m_mode) m_secs = 0;
    m_mode = nm;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st     = 2'(m_mode);
    e.ring   = (m_mode == 2);
    e.snz    = (m_mode == 3);
    e.buz    = (m_mode == 2) && (m_secs % 2 == 0);
    e.missed = m_missed;
    e.sn     = 2'(m_sn);
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t a;
    a.st = u_if.alarm_state; a.ring = u_if.ringing; a.snz = u_if.snoozing;
    a.buz = u_if.buzzer; a.missed = u_if.missed; a.sn = u_if.snooze_cnt;
    return a;
  endfunction

  task automatic cyc(input bit tick, input bit snz, input bit stop);
    @(negedge clk);
    rst = d_rst;
    u_if.sec_tick = tick; u_if.snooze_btn = snz; u_if.stop_btn = stop;
    u_if.alarm_en = d_en; u_if.state_out = d_so;
    {u_if.hh_t, u_if.hh_u, u_if.mm_t, u_if.mm_u} = d_tm;
    {u_if.ah_t, u_if.ah_u, u_if.am_t, u_if.am_u} = d_al;
    model_step(tick, snz, stop);
    q_exp.push_back(model_out());
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin cyc(1, 0, 0); cyc(0, 0, 0); end
  endtask

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got st=%0d ring=%0b snz=%0b buz=%0b missed=%0b sn=%0d want st=%0d ring=%0b snz=%0b buz=%0b missed=%0b sn=%0d",
                  name, $time, got.st, got.ring, got.snz, got.buz, got.missed, got.sn,
                  want.st, want.ring, want.snz, want.buz, want.missed, want.sn);
  endtask

  // asynchronous reset asserted mid-cycle; outputs must drop before the next edge
  task automatic async_reset_check(input string name);
    exp_t zero;
    zero = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    d_rst = 0;
    #1 check(name, dut_out(), zero);
    cyc(0, 0, 0); cyc(0, 0, 0);
    d_rst = 1;
    cyc(0, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic ring_at_0645();
    d_tm = 16'h0644; cyc(0, 0, 0);
    d_tm = 16'h0645; cyc(0, 0, 0);
  endtask

  // monitor: every cycle the DUT presents registered outputs one edge after stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check("cycle_out", dut_out(), e);
      end
    end
  end

  initial begin
    exp_t zero;
    zero = '0;
    rst = 1'b0;
    d_rst = 0; d_en = 1; d_so = 2'd0; d_tm = 16'h0000; d_al = 16'h0000;
    u_if.sec_tick = 0; u_if.snooze_btn = 0; u_if.stop_btn = 0;
    u_if.alarm_en = 1; u_if.state_out = 0;
    {u_if.hh_t, u_if.hh_u, u_if.mm_t, u_if.mm_u} = 16'h0;
    {u_if.ah_t, u_if.ah_u, u_if.am_t, u_if.am_u} = 16'h0;
    #1 check("reset_init", dut_out(), zero);

    // time==alarm==00:00 at reset release: arms but never rings
    cyc(0, 0, 0); cyc(0, 0, 0);
    d_rst = 1;
    tick_n(5);

    // ring burst times out after RING ticks, sets missed
    d_al = 16'h0645;
    ring_at_0645();
    tick_n(RING);
    cyc(0, 0, 0);

    // snooze up to the limit, extra snooze ignored
    ring_at_0645();
    repeat (MAXSN) begin
      cyc(0, 1, 0);
      tick_n(SNOOZE);
    end
    cyc(0, 1, 0); cyc(0, 0, 0);
    // stop beats snooze in the same clock
    cyc(0, 1, 1); cyc(0, 0, 0);

    // inhibited rise in SET_TIME / SET_ALARM is lost
    d_tm = 16'h0644; cyc(0, 0, 0);
    d_so = 2'd1; d_tm = 16'h0645; cyc(0, 0, 0); cyc(0, 0, 0);
    d_so = 2'd0; cyc(0, 0, 0); tick_n(2);
    d_tm = 16'h0644; cyc(0, 0, 0);
    d_so = 2'd2; d_tm = 16'h0645; cyc(0, 0, 0);
    d_so = 2'd0; cyc(0, 0, 0); cyc(0, 0, 0);

    // stopwatch mode still fires
    d_tm = 16'h0644; cyc(0, 0, 0);
    d_so = 2'd3; d_tm = 16'h0645; cyc(0, 0, 0);
    tick_n(1); cyc(0, 0, 1);
    d_so = 2'd0;

    // disarm while ringing, then re-arm while matched (no ring)
    ring_at_0645(); tick_n(1);
    d_en = 0; cyc(0, 0, 0); cyc(0, 0, 0);
    d_en = 1; cyc(0, 0, 0); tick_n(2);

    // async reset mid-ring (buzzer high) and mid-snooze
    ring_at_0645();
    async_reset_check("async_reset_ring");
    ring_at_0645(); cyc(0, 1, 0); tick_n(2);
    async_reset_check("async_reset_snooze");

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      bit tk, sz, sp;
      tk = ($urandom % 4) == 0;
      sz = ($urandom % 10) == 0;
      sp = ($urandom % 60) == 0;
      if (($urandom % 250) == 0) d_en = ~d_en;
      if (($urandom % 150) == 0) d_so = 2'($urandom % 4);
      else if (d_so != 2'd0 && ($urandom % 20) == 0) d_so = 2'd0;
      if (($urandom % 20) == 0) begin
        case ($urandom % 3)
          0: d_tm = 16'h0644;
          1: d_tm = 16'h0645;
          default: d_tm = 16'h1200;
        endcase
      end
      if (($urandom % 1500) == 0) async_reset_check("async_reset_rand");
      cyc(tk, sz, sp);
    end

    cyc(0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    n_chk++;
    if (q_exp.size() == 0) n_pass++;
    else $display("FAIL queue_drain got %0d pending want 0", q_exp.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
